parity_frame_arbiter: RTL

PARITY_FRAME_ARBITER -- requirements
Module: parity_frame_arbiter

---
 rtl/parity_frame_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/parity_frame_arbiter.sv
// Two-requester byte-frame arbiter: grants one requester per frame (round-robin on ties),
// accumulates XOR parity and byte count, and presents one result per frame with backpressure.
module parity_frame_arbiter #(
    parameter bit PARITY_ODD = 1'b0,
    parameter int MAX_LEN    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_parity,
    output logic       res_id,
    output logic [7:0] res_count,
    output logic       res_err
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESULT
    } state_t;

    state_t     state;
    logic       grant;
    logic       last_grant;
    logic       acc;
    logic [7:0] count;

    logic       sel_valid;
    logic       sel_ready;
    logic       sel_last;
    logic [7:0] sel_data;
    logic       byte_par;
    logic       take;
    logic       next_grant;
    logic [7:0] count_inc;

    always_comb begin
        sel_valid  = grant ? req1_valid : req0_valid;
        sel_ready  = grant ? req1_ready : req0_ready;
        sel_last   = grant ? req1_last  : req0_last;
        sel_data   = grant ? req1_data  : req0_data;
        byte_par   = ^sel_data;
        take       = (state == BUSY) && sel_valid && sel_ready;
        count_inc  = count + 8'd1;
        // On a tie the requester that did not own the previous frame wins.
        next_grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            acc        <= 1'b0;
            count      <= 8'd0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            res_valid  <= 1'b0;
            res_parity <= 1'b0;
            res_id     <= 1'b0;
            res_count  <= 8'd0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        grant      <= next_grant;
                        req0_ready <= ~next_grant;
                        req1_ready <= next_grant;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (take) begin
                        acc   <= acc ^ byte_par;
                        count <= count_inc;
                        if (sel_last || (count_inc == MAX_CNT)) begin
                            req0_ready <= 1'b0;
                            req1_ready <= 1'b0;
                            res_valid  <= 1'b1;
                            res_parity <= acc ^ byte_par ^ PARITY_ODD;
                            res_id     <= grant;
                            res_count  <= count_inc;
                            res_err    <= ~sel_last;
                            state      <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        last_grant <= res_id;
                        acc        <= 1'b0;
                        count      <= 8'd0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req0_ready <= 1'b0;
                    req1_ready <= 1'b0;
                    res_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
